// File: rtl/photo_reader_emu.sv
// ---------------------------------------------------------------------------
// photo_reader_emu
//
// Device-side emulation of the G-15 photoelectric tape reader. The host
// pushes 5-bit tape frames into a small FIFO. The reader releases them onto
// PHOTO1..PHOTO5 at reader speed. Every timing step (start delay, frame
// spacing, starvation, tape stop) is taken from the drum word marker T0.
//
// Ports:
//   CLOCK          system clock
//   rst_n          asynchronous active-low reset
//   T0             one-CLOCK pulse at each drum word boundary
//   READ_CMD       level, the computer requests reader motion
//   host_data      tape frame, bit0 -> PHOTO1 ... bit4 -> PHOTO5
//   host_valid     host frame valid
//   host_ready     FIFO not full (combinational)
//   PHOTO1..5      frame bits presented to the I/O character logic
//   READER_BUSY    high in START, GAP and PRESENT
//   TAPE_STOPPED   one-CLOCK pulse when the stop frame is consumed
//   fifo_count     number of buffered frames
//
// Optional feature macro: G15_PHOTO_LEADER_SKIP_EN
//   When defined, blank (all-zero) leader/trailer frames are consumed at one
//   per word-time. They are not presented and they do not reload the gap.
// ---------------------------------------------------------------------------
module photo_reader_emu #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         START_WORDS = 2,
  parameter int         FRAME_WORDS = 4,
  parameter logic [4:0] STOP_CODE   = 5'b10000
) (
  input  logic                        CLOCK,
  input  logic                        rst_n,
  input  logic                        T0,
  input  logic                        READ_CMD,
  input  logic [4:0]                  host_data,
  input  logic                        host_valid,
  output logic                        host_ready,
  output logic                        PHOTO1,
  output logic                        PHOTO2,
  output logic                        PHOTO3,
  output logic                        PHOTO4,
  output logic                        PHOTO5,
  output logic                        READER_BUSY,
  output logic                        TAPE_STOPPED,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXW = (START_WORDS > FRAME_WORDS) ? START_WORDS : FRAME_WORDS;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_PRESENT,
    S_HALT
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [4:0]    head;

  assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign host_ready = ~full;
  assign push       = host_valid & ~full;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // NOTE: storage words are not reset. Only the pointers and the count define
  // which entries are valid, so stale data is never read.
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= host_data;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // The depth is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------- reader FSM
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dec;
  logic [4:0]    photo_q, photo_d;
  logic          read_cmd_q;
  logic          stop_hit;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      photo_q    <= '0;
      read_cmd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      photo_q    <= photo_d;
      read_cmd_q <= READ_CMD;
    end
  end

  // NOTE: every signal gets a default value before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    photo_d  = photo_q;
    pop      = 1'b0;
    stop_hit = 1'b0;
    cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (READ_CMD && !read_cmd_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (!READ_CMD) begin
          state_d = S_IDLE;
        end else if (T0) begin
          if (cnt_q == CW'(START_WORDS - 1)) begin
            state_d = S_GAP;
            cnt_d   = CW'(FRAME_WORDS);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // A T0 that brings the gap counter to zero (or finds it at zero) is a
      // frame opportunity. A falling READ_CMD takes priority over a
      // coincident T0, so nothing is popped in that cycle.
      S_GAP: begin
        if (!READ_CMD) begin
          state_d = S_IDLE;
        end else if (T0) begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0 && !empty) begin
            pop = 1'b1;
            if (head == STOP_CODE) begin
              stop_hit = 1'b1;
              state_d  = S_HALT;
            end
`ifdef G15_PHOTO_LEADER_SKIP_EN
            else if (head == 5'b00000) begin
              // The blank frame is consumed. The counter stays at zero, so
              // the next frame is eligible at the following T0.
              state_d = S_GAP;
            end
`endif
            else begin
              photo_d = head;
              state_d = S_PRESENT;
            end
          end
        end
      end

      // The frame is held for exactly one word. FRAME_WORDS-1 gap words then
      // follow, which gives one frame per FRAME_WORDS word-times.
      S_PRESENT: begin
        if (T0) begin
          photo_d = '0;
          cnt_d   = CW'(FRAME_WORDS - 1);
          state_d = READ_CMD ? S_GAP : S_IDLE;
        end
      end

      S_HALT: begin
        if (!READ_CMD) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    READER_BUSY  = (state_q == S_START) || (state_q == S_GAP) ||
                   (state_q == S_PRESENT);
    TAPE_STOPPED = stop_hit;
  end

  assign PHOTO1 = photo_q[0];
  assign PHOTO2 = photo_q[1];
  assign PHOTO3 = photo_q[2];
  assign PHOTO4 = photo_q[3];
  assign PHOTO5 = photo_q[4];

endmodule
